// File: rtl/weapon_pkg.sv
// Shared types and constants for the weapon attack controller.
// The ARCHER_HOLD state exists only when WEAPON_CTRL_ARCHER_EN is defined.
package weapon_pkg;

  localparam logic [1:0] CLASS_MELEE  = 2'b01;
  localparam logic [1:0] CLASS_ARCHER = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SWING_OUT,
    SWING_BACK,
    COOLDOWN
`ifdef WEAPON_CTRL_ARCHER_EN
    , ARCHER_HOLD
`endif
  } state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/click_edge_detect.sv
// Rising-edge detector: pulses while the level is high and the registered
// copy from the previous cycle is still low.
module click_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/weapon_attack_ctrl.sv
// Melee swing / cooldown sequencer with single-hit damage reporting.
// Define WEAPON_CTRL_ARCHER_EN to add the archer draw (ARCHER_HOLD) state.
module weapon_attack_ctrl
  import weapon_pkg::*;
#(
  parameter int SWING_FRAMES       = 6,
  parameter int SWING_STEP         = 4,
  parameter int COOLDOWN_FRAMES    = 10,
  parameter int DMG                = 5,
  parameter int ARCHER_HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        mouse_left,
  input  logic [1:0]  game_active,
  input  logic [1:0]  char_class,
  input  logic        alive,
  input  logic        melee_hit,
  output logic        attack_active,
  output logic [11:0] anim_x_offset,
  output logic        dmg_valid,
  output logic [7:0]  dmg_amount
);

  localparam int CNT_MAX = max_i(max_i(SWING_FRAMES, COOLDOWN_FRAMES), ARCHER_HOLD_FRAMES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [11:0]      STEP       = 12'(SWING_STEP);
  localparam logic [7:0]       DMG_V      = 8'(DMG);
  localparam logic [CNT_W-1:0] SWING_LAST = CNT_W'(SWING_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
`ifdef WEAPON_CTRL_ARCHER_EN
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ARCHER_HOLD_FRAMES - 1);
`endif

  if (SWING_FRAMES * SWING_STEP > 4095) begin : g_range_chk
    $error("SWING_FRAMES*SWING_STEP does not fit anim_x_offset");
  end

  state_e           state_q, state_d;
  logic [11:0]      offset_q, offset_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             dmg_q, dmg_d;
  logic             click;
  logic             swinging;
  logic             abort;
  logic             qualify;

  click_edge_detect u_click (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (mouse_left),
    .rise_o  (click)
  );

  assign swinging = (state_q == SWING_OUT) || (state_q == SWING_BACK);
  assign abort    = (state_q != IDLE) && (!alive || (game_active == 2'b00));
  assign qualify  = click && alive && (game_active != 2'b00);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    dmg_d    = 1'b0;
    if (abort) begin
      // Losing the game or the player drops straight to IDLE, no cooldown.
      state_d  = IDLE;
      offset_d = '0;
      cnt_d    = '0;
    end else begin
      if (swinging && melee_hit && !hit_q) begin
        dmg_d = 1'b1;
        hit_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (qualify && (char_class == CLASS_MELEE)) begin
            state_d  = SWING_OUT;
            offset_d = '0;
            cnt_d    = '0;
            hit_d    = 1'b0;
          end
`ifdef WEAPON_CTRL_ARCHER_EN
          else if (qualify && (char_class == CLASS_ARCHER)) begin
            state_d  = ARCHER_HOLD;
            offset_d = '0;
            cnt_d    = '0;
          end
`endif
        end
        SWING_OUT: begin
          if (frame_tick) begin
            offset_d = offset_q + STEP;
            if (cnt_q == SWING_LAST) begin
              state_d = SWING_BACK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SWING_BACK: begin
          if (frame_tick) begin
            if (offset_q <= STEP) begin
              offset_d = '0;
              state_d  = COOLDOWN;
              cnt_d    = '0;
            end else begin
              offset_d = offset_q - STEP;
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt_q == COOL_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
`ifdef WEAPON_CTRL_ARCHER_EN
        ARCHER_HOLD: begin
          if (frame_tick) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = COOLDOWN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d  = IDLE;
          offset_d = '0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      offset_q <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      dmg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      dmg_q    <= dmg_d;
    end
  end

`ifdef WEAPON_CTRL_ARCHER_EN
  assign attack_active = swinging || (state_q == ARCHER_HOLD);
`else
  assign attack_active = swinging;
`endif
  assign anim_x_offset = offset_q;
  assign dmg_valid     = dmg_q;
  assign dmg_amount    = dmg_q ? DMG_V : 8'd0;

endmodule

// File: tb/tb_weapon_attack_ctrl.sv
// Self-checking bench for weapon_attack_ctrl: randomized tick/hit timing
// checked against an arithmetic model of the swing profile and damage rules.
module tb_weapon_attack_ctrl;

  localparam int SF   = 6;
  localparam int STEP = 4;
  localparam int CF   = 10;
  localparam int DMG  = 5;
  localparam int AHF  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        mouse_left;
  logic [1:0]  game_active;
  logic [1:0]  char_class;
  logic        alive;
  logic        melee_hit;
  logic        attack_active;
  logic [11:0] anim_x_offset;
  logic        dmg_valid;
  logic [7:0]  dmg_amount;

  int errs   = 0;
  int checks = 0;
  int pulses = 0;
  logic prev_dmg = 1'b0;

  weapon_attack_ctrl #(
    .SWING_FRAMES(SF), .SWING_STEP(STEP), .COOLDOWN_FRAMES(CF),
    .DMG(DMG), .ARCHER_HOLD_FRAMES(AHF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mouse_left(mouse_left),
    .game_active(game_active), .char_class(char_class), .alive(alive),
    .melee_hit(melee_hit), .attack_active(attack_active),
    .anim_x_offset(anim_x_offset), .dmg_valid(dmg_valid), .dmg_amount(dmg_amount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Damage pulses are counted globally; amount must track valid every cycle.
  always @(negedge clk) begin
    if (dmg_valid === 1'b1) begin
      pulses++;
      chk("dmg_amount_valid", dmg_amount, DMG);
      chk("dmg_single_cycle", prev_dmg, 0);
    end else begin
      chk("dmg_amount_idle", dmg_amount, 0);
    end
    prev_dmg = dmg_valid;
  end

  function automatic int exp_off(input int k);
    if (k <= SF) return k * STEP;
    return (2 * SF - k) * STEP;
  endfunction

  task automatic step(input bit t, input bit h);
    frame_tick = t;
    melee_hit  = h;
    @(negedge clk);
    frame_tick = 1'b0;
    melee_hit  = 1'b0;
  endtask

  task automatic click(input bit with_tick);
    mouse_left = 1'b0;
    @(negedge clk);
    mouse_left = 1'b1;
    frame_tick = with_tick;
    @(negedge clk);
    mouse_left = 1'b0;
    frame_tick = 1'b0;
  endtask

  // Full swing from SWING_OUT entry to COOLDOWN entry with random tick spacing.
  task automatic swing_random(input int pre_hits, input int hit_pct, output int hits);
    int k, cyc;
    bit seen, t, h;
    k = 0; cyc = 0; seen = 0; hits = 0;
    while (k < 2 * SF) begin
      if (cyc >= 400) begin
        chk("swing_timeout", cyc, 0);
        break;
      end
      if (cyc < pre_hits) begin
        t = 1'b0; h = 1'b1;
      end else begin
        t = ($urandom_range(0, 2) == 0);
        h = ($urandom_range(0, 99) < hit_pct);
      end
      step(t, h);
      chk("swing_dmg_valid", dmg_valid, h && !seen);
      if (h) begin
        seen = 1'b1;
        hits++;
      end
      if (t) k++;
      chk("swing_offset", anim_x_offset, exp_off(k));
      chk("swing_active", attack_active, k < 2 * SF);
      cyc++;
    end
  endtask

  // COOLDOWN_FRAMES ticks; optionally probe that clicks are ignored at ticks 4 and 9.
  task automatic cooldown(input bit probe);
    int p0;
    p0 = pulses;
    for (int c = 1; c <= CF; c++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0);
      chk("cool_active", attack_active, 0);
      chk("cool_offset", anim_x_offset, 0);
      if (probe && (c == 4 || c == CF - 1)) begin
        click(1'b0);
        chk("cool_click_ignored", attack_active, 0);
      end
    end
    chk("cool_no_dmg", pulses, p0);
  endtask

  initial begin
    int hits, p0;
    rst_n = 1'b0; frame_tick = 1'b0; mouse_left = 1'b0; game_active = 2'b01;
    char_class = 2'b01; alive = 1'b1; melee_hit = 1'b0;
    #3;
    chk("rst_active", attack_active, 0);
    chk("rst_offset", anim_x_offset, 0);
    chk("rst_dmg_valid", dmg_valid, 0);
    chk("rst_dmg_amount", dmg_amount, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_active", attack_active, 0);

    // Click coinciding with a frame tick: new swing starts at offset 0.
    click(1'b1);
    chk("click_active", attack_active, 1);
    chk("click_offset0", anim_x_offset, 0);
    p0 = pulses;
    swing_random(0, 0, hits);
    chk("swing1_pulses", pulses - p0, 0);
    cooldown(1'b1);

    // Cooldown expired: the next click must start a swing.
    click(1'b0);
    chk("post_cool_active", attack_active, 1);
    p0 = pulses;
    swing_random(3, 30, hits);
    chk("multi_hit_one_pulse", pulses - p0, 1);
    cooldown(1'b0);

    // Random hit density over several swings.
    for (int s = 0; s < 3; s++) begin
      click(1'b0);
      chk("rand_click_active", attack_active, 1);
      p0 = pulses;
      swing_random(0, $urandom_range(0, 15), hits);
      chk("rand_pulses", pulses - p0, (hits > 0) ? 1 : 0);
      cooldown(1'b0);
    end

    // IDLE gating: dead player, stopped game, unknown class.
    alive = 1'b0; click(1'b0); chk("gate_dead", attack_active, 0); alive = 1'b1;
    game_active = 2'b00; click(1'b0); chk("gate_game", attack_active, 0); game_active = 2'b10;
    char_class = 2'b00; click(1'b0); chk("gate_class", attack_active, 0); char_class = 2'b01;

    // Death after three swing ticks aborts to IDLE, hit in same cycle ignored.
    click(1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0);
      chk("abort_pre_offset", anim_x_offset, k * STEP);
    end
    p0 = pulses;
    alive = 1'b0;
    step(1'b0, 1'b1);
    chk("abort_active", attack_active, 0);
    chk("abort_offset", anim_x_offset, 0);
    chk("abort_dmg", dmg_valid, 0);
    step(1'b0, 1'b1);
    chk("abort_dmg_after", dmg_valid, 0);
    chk("abort_pulses", pulses, p0);
    alive = 1'b1;
    click(1'b0);
    chk("abort_no_cooldown", attack_active, 1);
    game_active = 2'b00;
    step(1'b1, 1'b0);
    chk("game_stop_active", attack_active, 0);
    chk("game_stop_offset", anim_x_offset, 0);
    game_active = 2'b01;

    // Asynchronous reset mid SWING_BACK with a damage pulse in flight.
    click(1'b0);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0);
    chk("pre_rst_offset", anim_x_offset, exp_off(8));
    melee_hit = 1'b1;
    @(posedge clk); #1;
    melee_hit = 1'b0;
    chk("pre_rst_dmg", dmg_valid, 1);
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    chk("async_rst_active", attack_active, 0);
    chk("async_rst_offset", anim_x_offset, 0);
    chk("async_rst_dmg_valid", dmg_valid, 0);
    chk("async_rst_dmg_amount", dmg_amount, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("post_rst_active", attack_active, 0);
      chk("post_rst_dmg", dmg_valid, 0);
    end
    chk("post_rst_pulses", pulses, p0);
    click(1'b0);
    chk("post_rst_click", attack_active, 1);
    chk("post_rst_offset", anim_x_offset, 0);
    swing_random(0, 5, hits);
    cooldown(1'b0);

    // Archer click.
    char_class = 2'b10;
    p0 = pulses;
    click(1'b0);
`ifdef WEAPON_CTRL_ARCHER_EN
    chk("archer_active", attack_active, 1);
    for (int k = 1; k <= AHF; k++) begin
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      chk("archer_hold_active", attack_active, k < AHF);
      chk("archer_offset", anim_x_offset, 0);
    end
    chk("archer_no_dmg", pulses, p0);
    cooldown(1'b0);
`else
    chk("archer_ignored", attack_active, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1);
      chk("archer_ignored_active", attack_active, 0);
      chk("archer_ignored_offset", anim_x_offset, 0);
    end
    chk("archer_ignored_dmg", pulses, p0);
`endif
    char_class = 2'b01;
    click(1'b0);
    chk("final_melee_click", attack_active, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
